// File: rtl/ccd_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module      : ccd_frame_packer
//  Description : Packs reduced camera pixels into wide DMEM words. Supports
//                single-shot and continuous capture, pads short frames with
//                zero words and aborts cleanly when the request drops.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccd_frame_packer #(
    parameter int IN_W      = 12,
    parameter int PIX_W     = 8,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int WORD_W    = 256,
    parameter int ADDR_W    = 7,
    parameter int BASE_ADDR = 0
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iEnable,
    input  logic              iMode,
    input  logic              iBinarize,
    input  logic              iInvert,
    input  logic [PIX_W-1:0]  iThresh,
    input  logic              iFVAL,
    input  logic              iDVAL,
    input  logic [IN_W-1:0]   iDATA,
    output logic              oDone,
    output logic              oFrameDone,
    output logic              oShort,
    output logic              oWren,
    output logic [ADDR_W-1:0] oAddr,
    output logic [WORD_W-1:0] oData,
    output logic [2:0]        oState
);

    localparam int NPIX   = IMG_W * IMG_H;
    localparam int PPW    = WORD_W / PIX_W;
    localparam int NWORDS = (NPIX + PPW - 1) / PPW;
    localparam int PC_W   = $clog2(NPIX + 1);
    localparam int WC_W   = $clog2(NWORDS + 1);
    localparam int SL_W   = (PPW > 1) ? $clog2(PPW) : 1;

    // Geometry sanity: caught at elaboration, never handled at run time.
    if (BASE_ADDR + NWORDS - 1 >= (1 << ADDR_W)) begin : g_addr_range_err
        $error("ccd_frame_packer: frame does not fit in the DMEM address space");
    end
    if ((PIX_W > IN_W) || ((WORD_W % PIX_W) != 0)) begin : g_pix_w_err
        $error("ccd_frame_packer: PIX_W must be <= IN_W and divide WORD_W");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_CAPTURE = 3'd2,
        S_FLUSH   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic                bin_q, bin_d;
    logic                inv_q, inv_d;
    logic [PIX_W-1:0]    thresh_q, thresh_d;
    logic                seen_low_q, seen_low_d;
    logic [PC_W-1:0]     pix_q, pix_d;
    logic [SL_W-1:0]     slot_q, slot_d;
    logic [WC_W-1:0]     widx_q, widx_d;
    logic [WORD_W-1:0]   buf_q, buf_d;
    logic                done_q, done_d;
    logic                fdone_q, fdone_d;
    logic                short_q, short_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   data_q, data_d;

    logic [PIX_W-1:0]    w_trunc;
    logic [PIX_W-1:0]    w_pix;
    logic [WORD_W-1:0]   w_merged;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_unused_lsbs;

    assign w_unused_lsbs = ^iDATA;
    assign w_trunc       = iDATA[IN_W-1 -: PIX_W];
    assign w_addr        = ADDR_W'(BASE_ADDR) + ADDR_W'(widx_q);

    // Convert the incoming pixel and merge it into the pending word.
    always_comb begin
        w_pix = w_trunc;
        if (bin_q) begin
            w_pix = (w_trunc >= thresh_q) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
        end
        if (inv_q) begin
            w_pix = ~w_pix;
        end
        w_merged = buf_q;
        w_merged[int'(slot_q)*PIX_W +: PIX_W] = w_pix;
    end

    // Next-state and registered-output computation for the capture FSM.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        bin_d      = bin_q;
        inv_d      = inv_q;
        thresh_d   = thresh_q;
        seen_low_d = seen_low_q;
        pix_d      = pix_q;
        slot_d     = slot_q;
        widx_d     = widx_q;
        buf_d      = buf_q;
        done_d     = done_q;
        fdone_d    = 1'b0;
        short_d    = short_q;
        wren_d     = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;

        case (state_q)
            S_IDLE: begin
                if (iEnable) begin
                    state_d    = S_ARM;
                    mode_d     = iMode;
                    bin_d      = iBinarize;
                    inv_d      = iInvert;
                    thresh_d   = iThresh;
                    short_d    = 1'b0;
                    seen_low_d = 1'b0;
                    pix_d      = '0;
                    slot_d     = '0;
                    widx_d     = '0;
                    buf_d      = '0;
                end
            end
            S_ARM: begin
                // A frame already running when we arm is skipped entirely.
                if (!iEnable) begin
                    state_d = S_IDLE;
                end else if (!iFVAL) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!iEnable) begin
                    state_d = S_IDLE;
                end else if (!iFVAL) begin
                    short_d = 1'b1;
                    state_d = S_FLUSH;
                end else if (iDVAL) begin
                    pix_d = pix_q + 1'b1;
                    if (slot_q == SL_W'(PPW - 1)) begin
                        wren_d = 1'b1;
                        addr_d = w_addr;
                        data_d = w_merged;
                        widx_d = widx_q + 1'b1;
                        buf_d  = '0;
                        slot_d = '0;
                    end else begin
                        buf_d  = w_merged;
                        slot_d = slot_q + 1'b1;
                    end
                    if (pix_q == PC_W'(NPIX - 1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // Pending partial word first (already zero-filled), then zeros.
                if (widx_q != WC_W'(NWORDS)) begin
                    wren_d = 1'b1;
                    addr_d = w_addr;
                    data_d = buf_q;
                    widx_d = widx_q + 1'b1;
                    buf_d  = '0;
                    slot_d = '0;
                end else begin
                    fdone_d = 1'b1;
                    if (!mode_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (iEnable) begin
                        state_d    = S_ARM;
                        seen_low_d = 1'b0;
                        pix_d      = '0;
                        slot_d     = '0;
                        widx_d     = '0;
                        buf_d      = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                if (!iEnable) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            bin_q      <= 1'b0;
            inv_q      <= 1'b0;
            thresh_q   <= '0;
            seen_low_q <= 1'b0;
            pix_q      <= '0;
            slot_q     <= '0;
            widx_q     <= '0;
            buf_q      <= '0;
            done_q     <= 1'b0;
            fdone_q    <= 1'b0;
            short_q    <= 1'b0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            bin_q      <= bin_d;
            inv_q      <= inv_d;
            thresh_q   <= thresh_d;
            seen_low_q <= seen_low_d;
            pix_q      <= pix_d;
            slot_q     <= slot_d;
            widx_q     <= widx_d;
            buf_q      <= buf_d;
            done_q     <= done_d;
            fdone_q    <= fdone_d;
            short_q    <= short_d;
            wren_q     <= wren_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign oDone      = done_q;
    assign oFrameDone = fdone_q;
    assign oShort     = short_q;
    assign oWren      = wren_q;
    assign oAddr      = addr_q;
    assign oData      = data_q;
    assign oState     = state_q;

endmodule
`default_nettype wire
